// File: rtl/hdmi_video_timing.sv
// rtl/hdmi_video_timing.sv - ADV7513 parallel video timing generator with frame-complete idle gating.
// Optional colour-bar source enabled by defining TEST_PATTERN_EN.
module hdmi_video_timing #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        active,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_total_check
            $error("hdmi_video_timing: H_TOTAL/V_TOTAL must not exceed 2047");
        end
    endgenerate

    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] hctr_q, hctr_d;
    logic [10:0] vctr_q, vctr_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        frame_start_q, frame_start_d;
    logic        active_q, active_d;
    logic        last_h;
    logic        last_pix;
    logic        running;
    logic [10:0] hctr_adv;
    logic [10:0] vctr_adv;

    always_comb begin
        last_h   = (hctr_q == H_LAST);
        last_pix = last_h && (vctr_q == V_LAST);
        hctr_adv = last_h ? 11'd0 : hctr_q + 11'd1;
        vctr_adv = vctr_q;
        if (last_h) begin
            vctr_adv = (vctr_q == V_LAST) ? 11'd0 : vctr_q + 11'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        hctr_d  = hctr_q;
        vctr_d  = vctr_q;
        case (state_q)
            ST_IDLE: begin
                hctr_d = 11'd0;
                vctr_d = 11'd0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                hctr_d = hctr_adv;
                vctr_d = vctr_adv;
                if (!enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Keep counting so the frame in flight finishes; re-enable resumes seamlessly.
                hctr_d = hctr_adv;
                vctr_d = vctr_adv;
                if (enable) begin
                    state_d = ST_RUN;
                end else if (last_pix) begin
                    state_d = ST_IDLE;
                    hctr_d  = 11'd0;
                    vctr_d  = 11'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hctr_d  = 11'd0;
                vctr_d  = 11'd0;
            end
        endcase
    end

    always_comb begin
        running       = (state_q != ST_IDLE);
        de_d          = running && (hctr_q < H_ACT_L) && (vctr_q < V_ACT_L);
        hsync_d       = (running && hctr_q >= HS_START && hctr_q < HS_END) ? HS_POL : ~HS_POL;
        vsync_d       = (running && vctr_q >= VS_START && vctr_q < VS_END) ? VS_POL : ~VS_POL;
        x_d           = de_d ? hctr_q : x_q;
        y_d           = de_d ? vctr_q : y_q;
        frame_start_d = running && (hctr_q == 11'd0) && (vctr_q == 11'd0);
        active_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hctr_q        <= 11'd0;
            vctr_q        <= 11'd0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= 11'd0;
            y_q           <= 11'd0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hctr_q        <= hctr_d;
            vctr_q        <= vctr_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
        end
    end

`ifdef TEST_PATTERN_EN
    generate
        if (H_ACTIVE < 8) begin : g_bar_check
            $error("hdmi_video_timing: H_ACTIVE must be at least 8 for colour bars");
        end
    endgenerate

    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] bar_raw;
    logic [2:0]  bar_idx;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        bar_raw = hctr_q / BAR_W;
        bar_idx = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
        rgb_d   = 24'h000000;
        if (de_d) begin
            case (bar_idx)
                3'd0:    rgb_d = 24'hFFFFFF;
                3'd1:    rgb_d = 24'hFFFF00;
                3'd2:    rgb_d = 24'h00FFFF;
                3'd3:    rgb_d = 24'h00FF00;
                3'd4:    rgb_d = 24'hFF00FF;
                3'd5:    rgb_d = 24'hFF0000;
                3'd6:    rgb_d = 24'h0000FF;
                default: rgb_d = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;
`else
    assign rgb = 24'h000000;
`endif

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign active      = active_q;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb/tb_hdmi_video_timing.sv - directed bench for hdmi_video_timing with 16x8 total raster.
module tb_hdmi_video_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        frame_start;
    logic        active;
    logic [23:0] rgb;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_x;
    logic [10:0] exp_y;
    int          fs_count;
    int          de_count;
    int          hs_low_count;
    int          vs_low_count;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .active     (active),
        .rgb        (rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // k = pixel index within the run since the first frame start (outputs one edge behind counters).
    task automatic expect_k(input int k, input logic exp_active);
        int          h;
        int          v;
        logic        de_e;
        logic [23:0] rgb_e;
        h    = k % 16;
        v    = (k / 16) % 8;
        de_e = (h < 8) && (v < 4);
        if (de_e) begin
            exp_x = 11'(h);
            exp_y = 11'(v);
        end
        rgb_e = 24'h0;
`ifdef TEST_PATTERN_EN
        if (de_e) rgb_e = BARS[h];
`endif
        check($sformatf("de@%0d", k), 32'(de), 32'(de_e));
        check($sformatf("hsync@%0d", k), 32'(hsync), 32'((h >= 10 && h < 13) ? 0 : 1));
        check($sformatf("vsync@%0d", k), 32'(vsync), 32'((v >= 5 && v < 7) ? 0 : 1));
        check($sformatf("x@%0d", k), 32'(x), 32'(exp_x));
        check($sformatf("y@%0d", k), 32'(y), 32'(exp_y));
        check($sformatf("fs@%0d", k), 32'(frame_start), 32'((k % 128) == 0));
        check($sformatf("rgb@%0d", k), 32'(rgb), 32'(rgb_e));
        check($sformatf("active@%0d", k), 32'(active), 32'(exp_active));
        if (frame_start) fs_count++;
        if (de) de_count++;
        if (!hsync) hs_low_count++;
        if (!vsync) vs_low_count++;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_de"}, 32'(de), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
        check({tag, "_active"}, 32'(active), 32'd0);
        check({tag, "_x"}, 32'(x), 32'(exp_x));
        check({tag, "_y"}, 32'(y), 32'(exp_y));
        check({tag, "_rgb"}, 32'(rgb), 32'd0);
        if (frame_start) fs_count++;
    endtask

    // Reset, then raise enable so that outputs reflect pixel (0,0) on return.
    task automatic start();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        exp_x = 11'd0;
        exp_y = 11'd0;
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        check("e0_active", 32'(active), 32'd1);
        check("e0_de", 32'(de), 32'd0);
        fs_count     = 0;
        de_count     = 0;
        hs_low_count = 0;
        vs_low_count = 0;
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        exp_x  = 11'd0;
        exp_y  = 11'd0;
        fs_count = 0;
        tick();
        tick();
        expect_idle("reset");

        // Free run across two frames with per-frame statistics.
        start();
        for (int k = 0; k < 256; k++) begin
            if (k > 0) tick();
            expect_k(k, 1'b1);
            if (k == 127) begin
                check("frame_de_cycles", 32'(de_count), 32'd32);
                check("frame_hs_low", 32'(hs_low_count), 32'd24);
                check("frame_vs_low", 32'(vs_low_count), 32'd32);
                check("frame_fs_count", 32'(fs_count), 32'd1);
            end
        end
        check("two_frame_fs_count", 32'(fs_count), 32'd2);

        // Drop enable at line 2: frame drains to (15,7) then idles.
        start();
        for (int k = 0; k < 128; k++) begin
            if (k > 0) tick();
            expect_k(k, k < 127);
            if (k == 31) enable = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle("drained");
        end
        check("drain_fs_total", 32'(fs_count), 32'd1);

        // Re-enable during drain: timing must continue into the next frame untouched.
        start();
        for (int k = 0; k < 256; k++) begin
            if (k > 0) tick();
            expect_k(k, 1'b1);
            if (k == 31) enable = 1'b0;
            if (k == 63) enable = 1'b1;
        end
        check("redrain_fs_total", 32'(fs_count), 32'd2);

        // Reset mid-frame with counters at hctr=3 of line 1.
        start();
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) tick();
            expect_k(k, 1'b1);
        end
        reset = 1'b1;
        tick();
        exp_x = 11'd0;
        exp_y = 11'd0;
        expect_idle("midreset");
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        expect_idle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
